// File: rtl/alarm_ram_pkg.sv
// Shared types and constants for the alarm_ram_ctrl memory slave.
// Optional build macro used by the slice: ALARM_RAM_PARITY_EN.
package alarm_ram_pkg;

  // Controller phases: zero-fill after reset, then normal bus traffic.
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  // Legal read latencies (accept -> readdatavalid).
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  // Width of one byte lane.
  localparam int BYTE_W = 8;

endpackage

// File: rtl/alarm_ram_array.sv
// Byte-enabled single-port synchronous RAM with a registered read port.
// One storage array per byte lane. With ALARM_RAM_PARITY_EN defined each lane
// also stores an even-parity bit and par_err flags a lane mismatch on the
// registered read word.
module alarm_ram_array
  import alarm_ram_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 13
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     we,
  input  logic                     re,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [DATA_W/BYTE_W-1:0] be,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata
`ifdef ALARM_RAM_PARITY_EN
  ,
  output logic                     par_err
`endif
);

  localparam int LANES = DATA_W / BYTE_W;
`ifdef ALARM_RAM_PARITY_EN
  localparam int LANE_W = BYTE_W + 1;
  logic [LANES-1:0] lane_err;
  assign par_err = |lane_err;
`else
  localparam int LANE_W = BYTE_W;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [LANE_W-1:0] mem [0:(1<<ADDR_W)-1];
      logic [LANE_W-1:0] rd_reg;
      logic [LANE_W-1:0] wr_word;

`ifdef ALARM_RAM_PARITY_EN
      // Parity bit makes the stored lane have an even number of ones.
      assign wr_word      = {^wdata[gi*BYTE_W +: BYTE_W], wdata[gi*BYTE_W +: BYTE_W]};
      assign lane_err[gi] = ^rd_reg;
`else
      assign wr_word = wdata[gi*BYTE_W +: BYTE_W];
`endif

      // Lane write, only when this byte lane is enabled.
      always_ff @(posedge clk) begin
        if (en && we && be[gi]) begin
          mem[addr] <= wr_word;
        end
      end

      // Registered read; holds its value between accepted reads.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          rd_reg <= '0;
        end else if (en && re) begin
          rd_reg <= mem[addr];
        end
      end

      assign rdata[gi*BYTE_W +: BYTE_W] = rd_reg[BYTE_W-1:0];
    end
  endgenerate

endmodule

// File: rtl/alarm_ram_ctrl.sv
// Avalon-MM slave wrapper around alarm_ram_array: post-reset zero-fill,
// waitrequest/clken handshake and a 1- or 2-stage read pipeline.
// Optional build macro: ALARM_RAM_PARITY_EN adds the readerror output.
module alarm_ram_ctrl
  import alarm_ram_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 13,
  parameter int RD_LAT         = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [ADDR_W-1:0]        address,
  input  logic [DATA_W/BYTE_W-1:0] byteenable,
  input  logic                     chipselect,
  input  logic                     read,
  input  logic                     write,
  input  logic [DATA_W-1:0]        writedata,
  input  logic                     clken,
  output logic [DATA_W-1:0]        readdata,
  output logic                     readdatavalid,
  output logic                     waitrequest,
  output logic                     init_done
`ifdef ALARM_RAM_PARITY_EN
  ,
  output logic                     readerror
`endif
);

  localparam int BE_W = DATA_W / BYTE_W;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] fill_cnt_reg, fill_cnt_next;
  logic              clearing;
  logic              acc_rd, acc_wr;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [BE_W-1:0]   ram_be;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;
  logic [RD_LAT-1:0] vld_reg;
`ifdef ALARM_RAM_PARITY_EN
  logic              par_err;
`endif

  // Next-state, fill counter and handshake outputs; reset overrides all.
  always_comb begin
    state_next    = state_reg;
    fill_cnt_next = fill_cnt_reg;
    waitrequest   = 1'b1;
    init_done     = 1'b0;
    clearing      = 1'b0;
    case (state_reg)
      ST_CLEAR: begin
        clearing = clken;
        if (clken) begin
          fill_cnt_next = fill_cnt_reg + ADDR_W'(1);
          if (&fill_cnt_reg) begin
            state_next = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        waitrequest = ~clken;
        init_done   = 1'b1;
      end
    endcase
    if (!reset_n) begin
      waitrequest = 1'b1;
      init_done   = 1'b0;
      clearing    = 1'b0;
    end
  end

  // FSM and fill counter registers; clken low freezes them.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
      fill_cnt_reg <= '0;
    end else if (clken) begin
      state_reg    <= state_next;
      fill_cnt_reg <= fill_cnt_next;
    end
  end

  // A write wins when read and write are raised together.
  assign acc_wr = chipselect & write & ~waitrequest;
  assign acc_rd = chipselect & read & ~write & ~waitrequest;

  assign ram_we    = clearing | acc_wr;
  assign ram_addr  = clearing ? fill_cnt_reg : address;
  assign ram_be    = clearing ? {BE_W{1'b1}} : byteenable;
  assign ram_wdata = clearing ? '0 : writedata;

  alarm_ram_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk     (clk),
    .rst_n   (reset_n),
    .en      (clken),
    .we      (ram_we),
    .re      (acc_rd),
    .addr    (ram_addr),
    .be      (ram_be),
    .wdata   (ram_wdata),
    .rdata   (ram_rdata)
`ifdef ALARM_RAM_PARITY_EN
    ,
    .par_err (par_err)
`endif
  );

  // Read-valid shift register; stage 0 tracks the array output register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld_reg <= '0;
    end else if (clken) begin
      vld_reg[0] <= acc_rd;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_reg[i] <= vld_reg[i-1];
      end
    end
  end

  // The strobe is suppressed in frozen cycles so a stalled read is not counted twice.
  assign readdatavalid = vld_reg[RD_LAT-1] & clken & reset_n;

  generate
    if (RD_LAT >= RD_LAT_MAX) begin : g_lat2
      logic [DATA_W-1:0] rdata_reg;
`ifdef ALARM_RAM_PARITY_EN
      logic              rerr_reg;
      assign readerror = rerr_reg & readdatavalid;
`endif
      // Extra output stage, loaded only when the array holds a fresh word.
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          rdata_reg <= '0;
`ifdef ALARM_RAM_PARITY_EN
          rerr_reg  <= 1'b0;
`endif
        end else if (clken && vld_reg[0]) begin
          rdata_reg <= ram_rdata;
`ifdef ALARM_RAM_PARITY_EN
          rerr_reg  <= par_err;
`endif
        end
      end
      assign readdata = rdata_reg;
    end else begin : g_lat1
      assign readdata = ram_rdata;
`ifdef ALARM_RAM_PARITY_EN
      assign readerror = par_err & readdatavalid;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_alarm_ram_ctrl.sv
// Bench for alarm_ram_ctrl: two instances (RD_LAT 1 and 2, 16 words) share
// the same directed stimulus; an enabled-cycle model predicts every output.
module tb_alarm_ram_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  address = '0;
  logic [3:0]  byteenable = '0;
  logic        chipselect = 1'b0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic        clken = 1'b1;
  logic [31:0] rd1, rd2;
  logic        rdv1, rdv2, wr1, wr2, id1, id2;
`ifdef ALARM_RAM_PARITY_EN
  logic        rerr1, rerr2;
`endif

  always #5 clk = ~clk;

  alarm_ram_ctrl #(.DATA_W(32), .ADDR_W(4), .RD_LAT(1), .CLEAR_ON_RESET(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
    .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
    .clken(clken), .readdata(rd1), .readdatavalid(rdv1), .waitrequest(wr1),
    .init_done(id1)
`ifdef ALARM_RAM_PARITY_EN
    , .readerror(rerr1)
`endif
  );

  alarm_ram_ctrl #(.DATA_W(32), .ADDR_W(4), .RD_LAT(2), .CLEAR_ON_RESET(1)) dut2 (
    .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
    .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
    .clken(clken), .readdata(rd2), .readdatavalid(rdv2), .waitrequest(wr2),
    .init_done(id2)
`ifdef ALARM_RAM_PARITY_EN
    , .readerror(rerr2)
`endif
  );

  // Counters and model state
  int          vec_n = 0;
  int          miss_n = 0;
  logic [31:0] mem_m [16];
  int          clear_left = 16;
  int          ecnt = 0;
  int          cyc_n = 0;
  int          due_q [2][$];
  logic [31:0] dat_q [2][$];
  logic [31:0] last_m [2];
  int          rdv_cnt [2];
  int          log2 [$];
  logic [31:0] rd_a [2];
  logic        rdv_a [2];

  assign rd_a[0]  = rd1;
  assign rd_a[1]  = rd2;
  assign rdv_a[0] = rdv1;
  assign rdv_a[1] = rdv2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_n++;
    if (act !== exp) begin
      miss_n++;
      $display("FAIL %s @cycle %0d: got %h want %h", name, cyc_n, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    chipselect = 1'b0;
    read       = 1'b0;
    write      = 1'b0;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    chipselect = 1'b1; write = 1'b1; read = 1'b0;
    address = a; writedata = d; byteenable = be;
    cyc();
    $display("write addr=%0d data=%h be=%b", a, d, be);
  endtask

  task automatic do_read(input logic [3:0] a);
    chipselect = 1'b1; read = 1'b1; write = 1'b0; address = a;
    cyc();
    $display("read  addr=%0d", a);
  endtask

  // Count waitrequest-high cycles from the current one; bounded.
  task automatic count_wait(output int n);
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (wr1 !== 1'b1) break;
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int n, c0, c1, s, n0;
    last_m[0] = '0; last_m[1] = '0;
    rdv_cnt[0] = 0; rdv_cnt[1] = 0;

    fork
      // Model and per-cycle compare
      forever begin
        logic exp_wr, exp_id, exp_v;
        @(negedge clk);
        cyc_n++;
        exp_wr = !reset_n || clear_left > 0 || !clken;
        exp_id = reset_n && clear_left == 0;
        chk("waitrequest1", 32'(wr1), 32'(exp_wr));
        chk("waitrequest2", 32'(wr2), 32'(exp_wr));
        chk("init_done1", 32'(id1), 32'(exp_id));
        chk("init_done2", 32'(id2), 32'(exp_id));
        for (int k = 0; k < 2; k++) begin
          exp_v = reset_n && clken && (due_q[k].size() > 0) && (due_q[k][0] == ecnt);
          chk($sformatf("readdatavalid_lat%0d", k + 1), 32'(rdv_a[k]), 32'(exp_v));
          if (rdv_a[k] === 1'b1) rdv_cnt[k]++;
          if (exp_v) begin
            chk($sformatf("readdata_lat%0d", k + 1), rd_a[k], dat_q[k][0]);
            last_m[k] = dat_q[k][0];
            void'(due_q[k].pop_front());
            void'(dat_q[k].pop_front());
          end else if (reset_n && due_q[k].size() == 0) begin
            chk($sformatf("readdata_hold_lat%0d", k + 1), rd_a[k], last_m[k]);
          end
        end
        if (rdv2 === 1'b1) log2.push_back(cyc_n);
        // Advance the model across the coming rising edge
        if (!reset_n) begin
          clear_left = 16;
          for (int k = 0; k < 2; k++) begin
            due_q[k].delete(); dat_q[k].delete(); last_m[k] = '0;
          end
        end else if (clken) begin
          if (clear_left > 0) begin
            mem_m[16 - clear_left] = '0;
            clear_left--;
          end else if (chipselect && write) begin
            for (int b = 0; b < 4; b++)
              if (byteenable[b]) mem_m[address][8*b +: 8] = writedata[8*b +: 8];
          end else if (chipselect && read) begin
            for (int k = 0; k < 2; k++) begin
              due_q[k].push_back(ecnt + k + 1);
              dat_q[k].push_back(mem_m[address]);
            end
          end
          ecnt++;
        end
      end
      begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
      end
    join_none

    // Reset then full zero-fill: 16 waitrequest cycles
    repeat (3) cyc();
    reset_n = 1'b1;
    count_wait(n);
    chk("clear_cycles", n, 16);
    chk("init_done_after_clear", 32'(id1), 1);
    $display("reset release: clear took %0d cycles", n);
    cyc();

    // Reset mid-CLEAR at fill_cnt=7 restarts the fill
    reset_n = 1'b0; cyc(); reset_n = 1'b1;
    repeat (7) cyc();
    reset_n = 1'b0; cyc(); reset_n = 1'b1;
    count_wait(n);
    chk("clear_restart_cycles", n, 16);
    $display("mid-clear reset: clear took %0d cycles", n);
    cyc();

    // All 16 words read back as zero
    c0 = rdv_cnt[0]; c1 = rdv_cnt[1];
    for (int i = 0; i < 16; i++) do_read(4'(i));
    idle();
    repeat (4) cyc();
    chk("zero_reads_lat1", rdv_cnt[0] - c0, 16);
    chk("zero_reads_lat2", rdv_cnt[1] - c1, 16);

    // Byte-lane merge
    do_write(4'd5, 32'hDEADBEEF, 4'b1111);
    do_write(4'd5, 32'h000000AA, 4'b0001);
    do_read(4'd5);
    idle();
    @(negedge clk);
    chk("merge_lat1", rd1, 32'hDEADBEAA);
    chk("merge_lat1_valid", 32'(rdv1), 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("merge_lat2", rd2, 32'hDEADBEAA);
    chk("merge_lat2_valid", 32'(rdv2), 1);
    chk("model_pin_addr5", mem_m[5], 32'hDEADBEAA);
    @(posedge clk); #1;

    // Read-after-write on consecutive cycles, then read+write together
    do_write(4'd9, 32'h13579BDF, 4'b1111);
    do_read(4'd9);
    c0 = rdv_cnt[0];
    chipselect = 1'b1; read = 1'b1; write = 1'b1;
    address = 4'd9; writedata = 32'h0BADF00D; byteenable = 4'b1100;
    cyc();
    $display("read+write addr=9 data=0badf00d be=1100");
    idle();
    repeat (3) cyc();
    chk("rw_single_valid", rdv_cnt[0] - c0, 1);
    chk("model_pin_addr9", mem_m[9], 32'h0BAD9BDF);
    do_read(4'd9);
    idle();
    @(negedge clk);
    chk("rw_result", rd1, 32'h0BAD9BDF);
    @(posedge clk); #1;
    repeat (2) cyc();

    // Back-to-back burst, RD_LAT=2 timing
    for (int i = 0; i < 8; i++) do_write(4'(i), 32'h10000000 + 32'(i) * 32'h01010101, 4'b1111);
    idle();
    repeat (3) cyc();
    s = cyc_n; n0 = log2.size();
    for (int i = 0; i < 8; i++) do_read(4'(i));
    idle();
    repeat (5) cyc();
    chk("burst_valid_count", log2.size() - n0, 8);
    for (int k = 0; k < 8; k++)
      if (n0 + k < log2.size()) chk($sformatf("burst_valid_cycle%0d", k), log2[n0 + k], s + 3 + k);

    // Burst with a 3-cycle clken gap
    c0 = rdv_cnt[0]; c1 = rdv_cnt[1];
    for (int i = 0; i < 8; i++) begin
      chipselect = 1'b1; read = 1'b1; write = 1'b0; address = 4'(i);
      if (i == 4) begin
        clken = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("gap_waitrequest", 32'(wr1), 1);
          chk("gap_valid", 32'({rdv1, rdv2}), 0);
          @(posedge clk); #1;
        end
        clken = 1'b1;
        $display("clken gap of 3 cycles before read %0d", i);
      end
      cyc();
      $display("read  addr=%0d", i);
    end
    idle();
    repeat (5) cyc();
    chk("gap_reads_lat1", rdv_cnt[0] - c0, 8);
    chk("gap_reads_lat2", rdv_cnt[1] - c1, 8);

`ifdef ALARM_RAM_PARITY_EN
    do_write(4'd3, 32'h12345678, 4'b1111);
    do_write(4'd4, 32'h0F0F0F0F, 4'b1111);
    idle();
    cyc();
    dut1.u_array.g_lane[2].mem[3][8] = ~dut1.u_array.g_lane[2].mem[3][8];
    do_read(4'd3);
    idle();
    @(negedge clk);
    chk("parity_bad", 32'({rdv1, rerr1}), 3);
    @(posedge clk); #1;
    do_read(4'd4);
    idle();
    @(negedge clk);
    chk("parity_clean", 32'({rdv1, rerr1}), 2);
    @(posedge clk); #1;
    repeat (3) cyc();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_n, miss_n);
    $finish;
  end

endmodule
